// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad driver.
package keypad_pkg;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned KEYS   = ROWS * COLS;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned PCNT_W = 8;

  localparam logic [1:0] ADDR_STATUS = 2'b00;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  // Entry idx = row*4+col; layout 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D, with * = E and # = F.
  localparam logic [KEYS-1:0][CODE_W-1:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_KEY   = 2'd1,
    FR_MULTI = 2'd2
  } frame_kind_e;

  typedef struct packed {
    frame_kind_e      kind;
    logic [IDX_W-1:0] idx;
  } frame_t;

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2,
    ROW3 = 2'd3
  } row_state_e;

  typedef enum logic {
    DB_IDLE = 1'b0,
    DB_HELD = 1'b1
  } db_mode_e;

  // Classify one full scan of asserted key bits.
  function automatic frame_t classify(input logic [KEYS-1:0] hits);
    frame_t      f;
    int unsigned n;
    f.kind = FR_NONE;
    f.idx  = '0;
    n      = 0;
    for (int unsigned i = 0; i < KEYS; i++) begin
      if (hits[i]) begin
        n     = n + 1;
        f.idx = IDX_W'(i);
      end
    end
    if (n == 1) begin
      f.kind = FR_KEY;
    end else if (n > 1) begin
      f.kind = FR_MULTI;
    end
    return f;
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Frame-level debouncer: one accept pulse per stable press, re-armed only by a stable release.
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_done,
  input  frame_t           frame,
  output logic             accept,
  output logic [IDX_W-1:0] accept_idx
);

  localparam int unsigned       CNT_W   = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  db_mode_e         mode_q, mode_d;
  frame_t           cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_q, accept_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= DB_IDLE;
      cand_q   <= '{kind: FR_NONE, idx: '0};
      cnt_q    <= '0;
      accept_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    idx_d    = idx_q;
    if (frame_done) begin
      if (frame == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cand_d = frame;
        cnt_d  = CNT_W'(1);
      end
      // Key changes while held are ignored until a stable release.
      if (cnt_d == CNT_MAX) begin
        if (mode_q == DB_IDLE) begin
          if (cand_d.kind == FR_KEY) begin
            mode_d   = DB_HELD;
            accept_d = 1'b1;
            idx_d    = cand_d.idx;
          end
        end else if (cand_d.kind == FR_NONE) begin
          mode_d = DB_IDLE;
        end
      end
    end
  end

  assign accept     = accept_q;
  assign accept_idx = idx_q;

endmodule

// File: rtl/keypad_driver.sv
// Memory-mapped 4x4 keypad driver: row scan, column sync, debounce, latched key event and read mux.
module keypad_driver
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIVIDE    = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              iFpgaClock,
  input  logic              iCpuResetN,
  input  logic              iDoKeypadRead,
  input  logic [1:0]        iKeypadAddress,
  output logic [DATA_W-1:0] oKeypadDataToRead,
  output logic [ROWS-1:0]   oKeypadRow,
  input  logic [COLS-1:0]   iKeypadColumn,
  output logic              oKeyValid
);

  localparam int unsigned        DWELL_W    = $clog2(SCAN_DIVIDE);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIVIDE - 1);

  logic [COLS-1:0]    col_meta_q, col_sync_q;
  row_state_e         state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [KEYS-1:0]    acc_q, acc_d;
  logic [ROWS-1:0]    row_q, row_d;
  logic [CODE_W-1:0]  keycode_q, keycode_d;
  logic               pending_q, pending_d;
  logic               overflow_q, overflow_d;
  logic [PCNT_W-1:0]  pcount_q, pcount_d;

  logic               frame_done_c;
  frame_t             frame_c;
  logic               accept;
  logic [IDX_W-1:0]   accept_idx;
  logic               rd_clr_c;

  always_ff @(posedge iFpgaClock or negedge iCpuResetN) begin
    if (!iCpuResetN) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
      state_q    <= ROW0;
      dwell_q    <= '0;
      acc_q      <= '0;
      row_q      <= 4'b1110;
      keycode_q  <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      pcount_q   <= '0;
    end else begin
      col_meta_q <= iKeypadColumn;
      col_sync_q <= col_meta_q;
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      acc_q      <= acc_d;
      row_q      <= row_d;
      keycode_q  <= keycode_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      pcount_q   <= pcount_d;
    end
  end

  // Row scan: sample columns on the last dwell cycle, classify after ROW3.
  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q + DWELL_W'(1);
    acc_d        = acc_q;
    frame_done_c = 1'b0;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      acc_d[{state_q, 2'b00} +: COLS] = ~col_sync_q;
      case (state_q)
        ROW0:    state_d = ROW1;
        ROW1:    state_d = ROW2;
        ROW2:    state_d = ROW3;
        default: begin
          state_d      = ROW0;
          frame_done_c = 1'b1;
        end
      endcase
    end
    row_d          = '1;
    row_d[state_d] = 1'b0;
    frame_c        = classify(acc_d);
    // Two or more keys may be ghost images, so they read as no key.
    if (frame_c.kind == FR_MULTI) begin
      frame_c.kind = FR_NONE;
      frame_c.idx  = '0;
    end
  end

  keypad_debouncer #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debouncer (
    .clk        (iFpgaClock),
    .rst_n      (iCpuResetN),
    .frame_done (frame_done_c),
    .frame      (frame_c),
    .accept     (accept),
    .accept_idx (accept_idx)
  );

  assign rd_clr_c = iDoKeypadRead && (iKeypadAddress == ADDR_STATUS);

  // Event registers; a new accept overrides a clearing read on the same edge.
  always_comb begin
    keycode_d  = keycode_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    pcount_d   = pcount_q;
    if (rd_clr_c) begin
      pending_d  = 1'b0;
      overflow_d = 1'b0;
    end
    if (accept) begin
      keycode_d  = KEYMAP[accept_idx];
      pcount_d   = pcount_q + PCNT_W'(1);
      overflow_d = !rd_clr_c && (overflow_q || pending_q);
      pending_d  = 1'b1;
    end
  end

  always_comb begin
    case (iKeypadAddress)
      ADDR_STATUS: oKeypadDataToRead = {overflow_q, 10'b0, pending_q, keycode_q};
      ADDR_COUNT:  oKeypadDataToRead = {8'b0, pcount_q};
      default:     oKeypadDataToRead = '0;
    endcase
  end

  assign oKeypadRow = row_q;
  assign oKeyValid  = pending_q;

endmodule

// File: tb/tb_keypad_driver.sv
// Self-checking bench for keypad_driver with a scoreboard of expected keycodes.
module tb_keypad_driver;

  localparam int unsigned SD    = 8;
  localparam int unsigned DS    = 2;
  localparam int          FRAME = 4 * SD;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic [1:0]  addr;
  logic [15:0] data;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        valid;

  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  logic        valid_prev;
  int          n_checks;
  int          n_fail;

  keypad_driver #(
    .SCAN_DIVIDE   (SD),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .iFpgaClock       (clk),
    .iCpuResetN       (rst_n),
    .iDoKeypadRead    (rd),
    .iKeypadAddress   (addr),
    .oKeypadDataToRead(data),
    .oKeypadRow       (row),
    .iKeypadColumn    (col),
    .oKeyValid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row drive onto its column.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4+c]) col[c] = 1'b0;
        end
      end
    end
  end

  function automatic logic [3:0] tb_keymap(input int idx);
    case (idx)
      0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
      4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
      8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hC;
      12: return 4'hE; 13: return 4'h0; 14: return 4'hF; default: return 4'hD;
    endcase
  endfunction

  // Scoreboard: each rising oKeyValid must match the oldest expected keycode.
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_prev = 1'b0;
    end else begin
      if (valid && !valid_prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got keycode %h, none expected", data[3:0]);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (addr !== 2'b00 || data[3:0] !== e) begin
            n_fail++;
            $display("FAIL event_keycode: got %h, expected %h", data[3:0], e);
          end
        end
      end
      valid_prev = valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [15:0] d);
    addr = a;
    #1;
    d    = data;
    addr = 2'b00;
  endtask

  task automatic clear_read();
    rd   = 1'b1;
    addr = 2'b00;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic reset_dut();
    keys  = '0;
    rd    = 1'b0;
    addr  = 2'b00;
    rst_n = 1'b0;
    tick(3);
    exp_q.delete();
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = 0;
    while (!valid && lat < budget) begin
      tick(1);
      lat++;
    end
    if (!valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid_timeout: oKeyValid=%b after %0d cycles, required 1", valid, lat);
    end
  endtask

  task automatic wait_frame_start();
    logic [3:0] prev;
    int         n;
    n = 0;
    do begin
      prev = row;
      tick(1);
      n++;
    end while (!(row == 4'b1110 && prev != 4'b1110) && n < 2 * FRAME);
    if (n >= 2 * FRAME) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_start_timeout: row=%b, required transition to 1110", row);
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    int          n;
    n_checks++;
    if (row !== 4'b1110 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: row=%b valid=%b, required 1110/0", row, valid);
    end
    keys = 16'h0020;
    tick(45);
    n = 0;
    while (row !== 4'b1011 && n < 2 * FRAME) begin
      tick(1);
      n++;
    end
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (row !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_row: got %b, required 1110", row);
    end
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b, required 0", valid);
    end
    peek(2'b00, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_status: got %h, required 0000", d);
    end
    peek(2'b10, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_count: got %h, required 0000", d);
    end
    keys = '0;
    tick(2);
    exp_q.delete();
    rst_n = 1'b1;
    tick(4 * FRAME);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_event: valid=%b, required 0", valid);
    end
  endtask

  task automatic test_single_press();
    logic [15:0] d;
    int          lat;
    exp_q.push_back(4'h6);
    keys = 16'h0040;
    wait_valid(4 * FRAME, lat);
    n_checks++;
    if (lat < FRAME + 8 || lat > 3 * FRAME + 8) begin
      n_fail++;
      $display("FAIL press_latency: got %0d cycles, required %0d..%0d", lat, FRAME + 8, 3 * FRAME + 8);
    end
    peek(2'b00, d);
    n_checks++;
    if (d !== 16'h0016) begin
      n_fail++;
      $display("FAIL press_status: got %h, required 0016", d);
    end
    peek(2'b10, d);
    n_checks++;
    if (d !== 16'h0001) begin
      n_fail++;
      $display("FAIL press_count: got %h, required 0001", d);
    end
    clear_read();
    peek(2'b00, d);
    n_checks++;
    if (valid !== 1'b0 || d !== 16'h0006) begin
      n_fail++;
      $display("FAIL press_clear: valid=%b status=%h, required 0/0006", valid, d);
    end
    keys = '0;
    tick(3 * FRAME);
  endtask

  task automatic test_bounce_ghost();
    logic [15:0] d;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 6; i++) begin
        keys[0] = ~keys[0];
        tick(5);
      end
      keys = '0;
      tick(40);
    end
    tick(3 * FRAME);
    peek(2'b10, d);
    n_checks++;
    if (valid !== 1'b0 || d !== 16'h0001) begin
      n_fail++;
      $display("FAIL bounce_reject: valid=%b count=%h, required 0/0001", valid, d);
    end
    keys = 16'h0021;
    tick(6 * FRAME);
    keys = '0;
    tick(3 * FRAME);
    peek(2'b10, d);
    n_checks++;
    if (valid !== 1'b0 || d !== 16'h0001) begin
      n_fail++;
      $display("FAIL ghost_reject: valid=%b count=%h, required 0/0001", valid, d);
    end
  endtask

  task automatic test_held_release();
    logic [15:0] d;
    int          lat;
    reset_dut();
    exp_q.push_back(4'hA);
    keys = 16'h0008;
    wait_valid(4 * FRAME, lat);
    clear_read();
    tick(10 * FRAME);
    peek(2'b10, d);
    n_checks++;
    if (valid !== 1'b0 || d !== 16'h0001) begin
      n_fail++;
      $display("FAIL held_single_event: valid=%b count=%h, required 0/0001", valid, d);
    end
    keys = '0;
    tick(3 * FRAME);
    exp_q.push_back(4'hA);
    keys = 16'h0008;
    wait_valid(4 * FRAME, lat);
    peek(2'b10, d);
    n_checks++;
    if (d !== 16'h0002) begin
      n_fail++;
      $display("FAIL repress_count: got %h, required 0002", d);
    end
    clear_read();
    keys = '0;
    tick(3 * FRAME);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL held_pending_expect: %0d events missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow_priority();
    logic [15:0] d;
    int          lat;
    int          n;
    reset_dut();
    exp_q.push_back(4'h1);
    keys = 16'h0001;
    wait_valid(4 * FRAME, lat);
    keys = '0;
    tick(3 * FRAME);
    keys = 16'h4000;
    n = 0;
    d = '0;
    while (d !== 16'h0002 && n < 4 * FRAME) begin
      tick(1);
      peek(2'b10, d);
      n++;
    end
    peek(2'b00, d);
    n_checks++;
    if (d !== 16'h801F) begin
      n_fail++;
      $display("FAIL overflow_status: got %h, required 801F", d);
    end
    keys = '0;
    tick(3 * FRAME);
    // Press aligned to a frame start: accept lands on the first edge after the second following frame start.
    wait_frame_start();
    keys = 16'h0002;
    wait_frame_start();
    wait_frame_start();
    clear_read();
    peek(2'b00, d);
    n_checks++;
    if (valid !== 1'b1 || d !== 16'h0012) begin
      n_fail++;
      $display("FAIL priority_status: valid=%b status=%h, required 1/0012", valid, d);
    end
    peek(2'b10, d);
    n_checks++;
    if (d !== 16'h0003) begin
      n_fail++;
      $display("FAIL priority_count: got %h, required 0003", d);
    end
    clear_read();
    peek(2'b00, d);
    n_checks++;
    if (valid !== 1'b0 || d !== 16'h0002) begin
      n_fail++;
      $display("FAIL priority_clear: valid=%b status=%h, required 0/0002", valid, d);
    end
    keys = '0;
    tick(3 * FRAME);
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    int          lat;
    reset_dut();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(tb_keymap(i % 16));
      keys = '0;
      keys[i % 16] = 1'b1;
      wait_valid(4 * FRAME, lat);
      clear_read();
      keys = '0;
      tick(3 * FRAME);
      if (i == 254) begin
        peek(2'b10, d);
        n_checks++;
        if (d !== 16'h00FF) begin
          n_fail++;
          $display("FAIL count_255: got %h, required 00FF", d);
        end
      end
    end
    peek(2'b10, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL count_wrap: got %h, required 0000", d);
    end
    peek(2'b01, d);
    n_checks++;
    if (d !== 16'h0000) begin
      n_fail++;
      $display("FAIL unmapped_addr: got %h, required 0000", d);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_pending_expect: %0d events missing, required 0", exp_q.size());
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    valid_prev = 1'b0;
    keys       = '0;
    rd         = 1'b0;
    addr       = 2'b00;
    rst_n      = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    test_reset();
    test_single_press();
    test_bounce_ghost();
    test_held_release();
    test_overflow_priority();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
